safe_code_entry: RTL and testbench

SAFE_CODE_ENTRY -- requirements
Module: safe_code_entry

---
 rtl/safe_pkg.sv | 14 +
 rtl/cycle_timer.sv | 35 +++
 rtl/safe_code_entry.sv | 182 ++++++++++++++++++
 tb/tb_safe_code_entry.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// Shared types and constants for the keypad safe controller.
package safe_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_OPEN,
    ST_LOCKOUT
  } state_e;

endpackage

// File: rtl/cycle_timer.sv
// Preset-and-run down-counter; done_p marks the last enabled cycle of the interval.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] preset,
  output logic             done_p
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = preset;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // A preset of N gives exactly N enabled cycles before done_p.
  assign done_p = enable && !load && (cnt_q == WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/safe_code_entry.sv
// Keypad combination lock: digit entry, unlock window and penalty lockout.
// Define SAFE_IDLE_TIMEOUT_EN to abandon a partial entry after IDLE_CYCLES of inactivity.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no digits entered, waiting for input
// ST_ENTRY   | partial or full combination being entered
// ST_OPEN    | correct code accepted, unlocked for OPEN_CYCLES
// ST_LOCKOUT | too many failures, inputs ignored for LOCK_CYCLES
module safe_code_entry
  import safe_pkg::*;
#(
  parameter int CODE_LEN    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 50_000_000,
  parameter int LOCK_CYCLES = 250_000_000,
  parameter int IDLE_CYCLES = 500_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               digit_p,
  input  logic [3:0]                         digit,
  input  logic                               enter_p,
  input  logic                               clear_p,
  input  logic [DIGIT_W*CODE_LEN-1:0]        code,
  output logic                               unlocked,
  output logic                               lockout,
  output logic                               err_p,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries,
  output logic [$clog2(CODE_LEN+1)-1:0]      count
);

  localparam int EW   = DIGIT_W * CODE_LEN;
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int TRW  = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] OPEN_PRE = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] LOCK_PRE = TW'(LOCK_CYCLES);

  if (CODE_LEN < 1 || MAX_TRIES < 1 || OPEN_CYCLES < 1 || LOCK_CYCLES < 1 ||
      IDLE_CYCLES < 1) begin : g_param_check
    $error("safe_code_entry: all parameters must be positive");
  end

  state_e          state_q, state_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TRW-1:0]  tries_q, tries_d;
  logic            err_q, err_d;

  logic            digit_ok;
  logic [TRW-1:0]  next_tries;
  logic            dur_load, dur_en, dur_done;
  logic [TW-1:0]   dur_preset;

  assign digit_ok   = digit_p && (digit <= MAX_DIGIT);
  assign next_tries = tries_q + TRW'(1);
  assign dur_en     = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);

  cycle_timer #(.WIDTH(TW)) u_dur_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (dur_load),
    .enable (dur_en),
    .preset (dur_preset),
    .done_p (dur_done)
  );

`ifdef SAFE_IDLE_TIMEOUT_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  logic idle_load, idle_done;

  cycle_timer #(.WIDTH(IW)) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (idle_load),
    .enable (state_q == ST_ENTRY),
    .preset (IW'(IDLE_CYCLES)),
    .done_p (idle_done)
  );
`endif

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    tries_d    = tries_q;
    err_d      = 1'b0;
    dur_load   = 1'b0;
    dur_preset = OPEN_PRE;
`ifdef SAFE_IDLE_TIMEOUT_EN
    idle_load  = 1'b0;
`endif

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        // clear_p outranks everything, even where it has nothing to discard.
        if (clear_p) begin
          entry_d = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end else if (enter_p) begin
          entry_d = '0;
          count_d = '0;
          if ((count_q == CW'(CODE_LEN)) && (entry_q == code)) begin
            state_d    = ST_OPEN;
            tries_d    = '0;
            dur_load   = 1'b1;
            dur_preset = OPEN_PRE;
          end else begin
            err_d   = 1'b1;
            tries_d = next_tries;
            if (next_tries == TRW'(MAX_TRIES)) begin
              state_d    = ST_LOCKOUT;
              dur_load   = 1'b1;
              dur_preset = LOCK_PRE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (digit_ok) begin
          state_d = ST_ENTRY;
`ifdef SAFE_IDLE_TIMEOUT_EN
          idle_load = 1'b1;
`endif
          if (count_q != CW'(CODE_LEN)) begin
            entry_d = (entry_q << DIGIT_W) | EW'(digit);
            count_d = count_q + CW'(1);
          end
        end
`ifdef SAFE_IDLE_TIMEOUT_EN
        else if ((state_q == ST_ENTRY) && idle_done) begin
          entry_d = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end
`endif
      end

      ST_OPEN: begin
        if (clear_p || dur_done) begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        if (dur_done) begin
          state_d = ST_IDLE;
          tries_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      entry_q <= '0;
      count_q <= '0;
      tries_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      tries_q <= tries_d;
      err_q   <= err_d;
    end
  end

  assign unlocked = (state_q == ST_OPEN);
  assign lockout  = (state_q == ST_LOCKOUT);
  assign err_p    = err_q;
  assign tries    = tries_q;
  assign count    = count_q;

endmodule

// File: tb/tb_safe_code_entry.sv
// Self-checking bench for safe_code_entry against a queue-based behavioural model.
// Honours SAFE_IDLE_TIMEOUT_EN in the same way as the design.
module tb_safe_code_entry;

  localparam int          CODE_LEN    = 4;
  localparam int          MAX_TRIES   = 3;
  localparam int          OPEN_CYCLES = 8;
  localparam int          LOCK_CYCLES = 16;
  localparam int          IDLE_CYCLES = 20;
  localparam logic [15:0] CODE        = 16'h1234;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        digit_p = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        enter_p = 1'b0;
  logic        clear_p = 1'b0;
  logic [15:0] code = CODE;
  logic        unlocked, lockout, err_p;
  logic [1:0]  tries;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int m_digs[$];
  bit m_open, m_lock, m_err;
  int open_left, lock_left, idle_left, m_tries;

  always #5 clk = ~clk;

  safe_code_entry #(
    .CODE_LEN    (CODE_LEN),
    .MAX_TRIES   (MAX_TRIES),
    .OPEN_CYCLES (OPEN_CYCLES),
    .LOCK_CYCLES (LOCK_CYCLES),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .digit_p  (digit_p),
    .digit    (digit),
    .enter_p  (enter_p),
    .clear_p  (clear_p),
    .code     (code),
    .unlocked (unlocked),
    .lockout  (lockout),
    .err_p    (err_p),
    .tries    (tries),
    .count    (count)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digs.delete();
    m_open = 0; m_lock = 0; m_err = 0;
    open_left = 0; lock_left = 0; idle_left = 0; m_tries = 0;
  endtask

  task automatic model_step(input bit dp, input int d, input bit ep, input bit cp);
    int val;
    m_err = 0;
    if (m_open) begin
      if (cp || open_left == 1) m_open = 0;
      else open_left--;
    end else if (m_lock) begin
      if (lock_left == 1) begin
        m_lock  = 0;
        m_tries = 0;
      end else lock_left--;
    end else if (cp) begin
      m_digs.delete();
    end else if (ep) begin
      val = 0;
      foreach (m_digs[i]) val = val * 16 + m_digs[i];
      if (m_digs.size() == CODE_LEN && val == int'(CODE)) begin
        m_open    = 1;
        open_left = OPEN_CYCLES;
        m_tries   = 0;
      end else begin
        m_err = 1;
        m_tries++;
        if (m_tries == MAX_TRIES) begin
          m_lock    = 1;
          lock_left = LOCK_CYCLES;
        end
      end
      m_digs.delete();
    end else if (dp && d <= 9) begin
      if (m_digs.size() < CODE_LEN) m_digs.push_back(d);
      idle_left = IDLE_CYCLES;
    end
`ifdef SAFE_IDLE_TIMEOUT_EN
    else if (m_digs.size() > 0) begin
      idle_left--;
      if (idle_left == 0) m_digs.delete();
    end
`endif
  endtask

  task automatic compare_all();
    check("unlocked", unlocked, m_open);
    check("lockout", lockout, m_lock);
    check("err_p", err_p, m_err);
    check("tries", tries, m_tries);
    check("count", count, m_digs.size());
  endtask

  // Called at a falling edge: drive, clock, update model, compare at next falling edge.
  task automatic cycle(input bit dp, input int d, input bit ep, input bit cp);
    digit_p = dp; digit = 4'(d); enter_p = ep; clear_p = cp;
    @(posedge clk);
    model_step(dp, d, ep, cp);
    @(negedge clk);
    digit_p = 0; enter_p = 0; clear_p = 0;
    compare_all();
  endtask

  task automatic press(input int d);  cycle(1, d, 0, 0); endtask
  task automatic enter();             cycle(0, 0, 1, 0); endtask
  task automatic clr();               cycle(0, 0, 0, 1); endtask
  task automatic idle(input int n);   for (int i = 0; i < n; i++) cycle(0, 0, 0, 0); endtask

  task automatic submit(input int a, input int b, input int c, input int e);
    press(a); press(b); press(c); press(e); enter();
  endtask

  initial begin
    int open_len, lock_len, r, idx, d;
    bit dp, ep, cp;
    model_reset();

    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b1;
    idle(2);

    // correct code: unlocked one cycle after enter, for exactly OPEN_CYCLES
    submit(1, 2, 3, 4);
    check("open_latency", unlocked, 1);
    open_len = 0;
    for (int i = 0; i < 20; i++) begin
      if (unlocked) open_len++;
      idle(1);
    end
    check("open_length", open_len, OPEN_CYCLES);
    check("open_tries", tries, 0);

    // three wrong attempts -> lockout; correct code ignored during lockout
    submit(1, 2, 3, 5);
    check("err1_tries", tries, 1);
    submit(1, 2, 3, 5);
    check("err2_tries", tries, 2);
    submit(1, 2, 3, 5);
    check("lockout_on", lockout, 1);
    lock_len = 1;
    submit(1, 2, 3, 4);
    lock_len += 5;
    for (int i = 0; i < 30; i++) begin
      if (lockout) lock_len++;
      idle(1);
    end
    check("lock_length", lock_len - 1, LOCK_CYCLES);
    check("lock_unlocked", unlocked, 0);
    check("lock_tries_after", tries, 0);

    // clear mid-entry, invalid digit ignored
    press(1); press(2); clr();
    check("clear_count", count, 0);
    press(1); press(2); press(4'hA);
    check("bad_digit_count", count, 2);
    press(3); press(4); enter();
    check("after_clear_open", unlocked, 1);
    idle(OPEN_CYCLES + 2);

    // clear beats enter; clear relocks at OPEN cycle 3
    press(1); press(2); press(3); press(4);
    cycle(0, 0, 1, 1);
    check("clr_enter_unlocked", unlocked, 0);
    check("clr_enter_err", err_p, 0);
    submit(1, 2, 3, 4);
    idle(2);
    check("open_cycle3", unlocked, 1);
    clr();
    check("relock", unlocked, 0);

    // saturation: fifth digit ignored
    press(1); press(2); press(3); press(4); press(7);
    check("saturate_count", count, 4);
    enter();
    idle(OPEN_CYCLES + 2);

    // partial entry under inactivity
    press(1); press(2);
    idle(IDLE_CYCLES + 3);
`ifdef SAFE_IDLE_TIMEOUT_EN
    check("idle_timeout_count", count, 0);
`else
    check("idle_persist_count", count, 2);
`endif
    check("idle_tries", tries, 0);
    clr();

    // asynchronous reset in the middle of a lockout
    submit(9, 9, 9, 9); submit(9, 9, 9, 9); submit(9, 9, 9, 9);
    idle(4);
    check("pre_rst_lockout", lockout, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_lockout", lockout, 0);
    check("async_rst_tries", tries, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle(2);
    submit(1, 2, 3, 4);
    check("post_rst_open", unlocked, 1);
    idle(OPEN_CYCLES + 2);

    // randomized traffic biased toward the correct code
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 99);
      dp = 0; ep = 0; cp = 0; d = 0;
      if (r < 4) cp = 1;
      else if (r < 14) ep = 1;
      else if (r < 75) begin
        dp  = 1;
        idx = m_digs.size();
        if (idx < CODE_LEN && $urandom_range(0, 3) != 0)
          d = (int'(CODE) >> (4 * (CODE_LEN - 1 - idx))) & 15;
        else
          d = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 19) == 0) cp = 1;
      if ($urandom_range(0, 19) == 0) ep = 1;
      if ($urandom_range(0, 19) == 0) begin dp = 1; d = $urandom_range(0, 15); end
      cycle(dp, d, ep, cp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
